// File: rtl/st_pkg.sv
// st_pkg: shared types and constants for the QDMA stream C2H generator and H2C checker.
package st_pkg;
   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
   typedef struct packed {
      logic [10:0] qid;
      logic [5:0]  mty;
      logic        zero_byte;
   } c2h_tuser_t;
   localparam logic [15:0] LFSR_SEED = 16'h0011;
   localparam logic [15:0] LFSR_TAPS = 16'h002D;
   function automatic int inc_data(int bw);
      return bw / 8;
   endfunction
   function automatic int wpb(int bw, int pw);
      return bw / pw;
   endfunction
endpackage

// File: rtl/c2h_pat_gen.sv
// c2h_pat_gen: one 16-bit word of the incrementing payload, bytes past the packet end zeroed.
module c2h_pat_gen #(
   parameter int K   = 0,
   parameter int INC = 8,
   parameter int WPB = 4
) (
   input  logic [15:0] beat,
   input  logic [5:0]  mty,
   output logic [15:0] word
);
   logic [15:0] pat;
   logic [6:0]  keep;
   assign pat  = beat * 16'(WPB) + 16'(K);
   assign keep = 7'(INC) - {1'b0, mty};
   assign word = {(7'(2 * K + 1) < keep) ? pat[15:8] : 8'h00, (7'(2 * K) < keep) ? pat[7:0] : 8'h00};
endmodule

// File: rtl/st_c2h_gen.sv
// st_c2h_gen: QDMA C2H stream traffic generator emitting a 16-bit incrementing payload.
// Define C2H_TVALID_THROTTLE_EN to add LFSR-driven tvalid throttling under control_reg[1].
module st_c2h_gen #(
   parameter int BIT_WIDTH  = 64,
   parameter int PATT_WIDTH = 16
) (
   input  logic                 axi_aclk,
   input  logic                 axi_aresetn,
   input  logic [31:0]          control_reg,
   input  logic                 control_run,
   input  logic [31:0]          c2h_txr_size,
   input  logic [31:0]          c2h_num_pkt,
   input  logic [10:0]          c2h_qid,
   input  logic                 c2h_tready,
   output logic [BIT_WIDTH-1:0] c2h_tdata,
   output logic                 c2h_tvalid,
   output logic                 c2h_tlast,
   output logic [10:0]          c2h_tuser_qid,
   output logic [5:0]           c2h_tuser_mty,
   output logic                 c2h_tuser_zero_byte,
   output logic [31:0]          c2h_pkt_count,
   output logic                 c2h_done
);
   import st_pkg::*;
   localparam int INC = inc_data(BIT_WIDTH);
   localparam int WPB = wpb(BIT_WIDTH, PATT_WIDTH);
   localparam int LOG = $clog2(INC);
   state_t               state_q, state_d;
   logic                 run_d1_q;
   logic [15:0]          size_q, size_d, beat_q, beat_d;
   logic [31:0]          num_q, num_d, pkt_q, pkt_d, pkt_inc;
   logic [BIT_WIDTH-1:0] tdata_q, tdata_d, pat;
   logic                 tvalid_q, tvalid_d, tlast_q, tlast_d, done_q, done_d;
   c2h_tuser_t           tuser_q, tuser_d;
   logic [16:0]          nbeats;
   logic [5:0]           mty_last, ld_mty;
   logic                 last_beat, rise, accept, finish, throttle, unused_bits;

   assign nbeats    = (size_q == 16'd0) ? 17'd1 : ({1'b0, size_q} + 17'(INC - 1)) >> LOG;
   assign last_beat = {1'b0, beat_q} == nbeats - 17'd1;
   assign mty_last  = 6'(7'(INC) - 7'(size_q[LOG-1:0])) & 6'(INC - 1);
   assign ld_mty    = last_beat ? mty_last : 6'd0;
   assign rise      = control_run & ~run_d1_q;
   assign accept    = tvalid_q & c2h_tready;
   assign pkt_inc   = pkt_q + 32'd1;
   assign finish    = accept & tlast_q & ((pkt_inc == num_q) | ~control_run);
   assign unused_bits = ^{control_reg, c2h_txr_size[31:16]};

   for (genvar k = 0; k < WPB; k++) begin : g_word
      c2h_pat_gen #(.K(k), .INC(INC), .WPB(WPB)) u_pat (
         .beat (beat_q),
         .mty  (ld_mty),
         .word (pat[16*k +: 16])
      );
   end

`ifdef C2H_TVALID_THROTTLE_EN
   logic [15:0] lfsr_q, lfsr_d;
   assign lfsr_d   = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
   assign throttle = control_reg[1] & lfsr_q[0];
   always_ff @(posedge axi_aclk or negedge axi_aresetn)
      if (!axi_aresetn) lfsr_q <= LFSR_SEED;
      else lfsr_q <= lfsr_d;
`else
   assign throttle = 1'b0;
`endif

   // beat_q is the index of the next beat to load, so the following packet can load right behind tlast
   always_comb begin
      state_d  = state_q;
      size_d   = size_q;
      num_d    = num_q;
      pkt_d    = pkt_q;
      beat_d   = beat_q;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      tuser_d  = tuser_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: if (rise) begin
            size_d      = c2h_txr_size[15:0];
            num_d       = c2h_num_pkt;
            tuser_d.qid = c2h_qid;
            pkt_d       = '0;
            beat_d      = '0;
            state_d     = (c2h_num_pkt == 32'd0) ? DONE : SEND;
            done_d      = c2h_num_pkt == 32'd0;
         end
         SEND: begin
            if (accept & tlast_q) pkt_d = pkt_inc;
            if (finish) begin
               state_d  = DONE;
               done_d   = 1'b1;
               tvalid_d = 1'b0;
               tlast_d  = 1'b0;
            end else if ((~tvalid_q | c2h_tready) & ~throttle) begin
               tvalid_d          = 1'b1;
               tdata_d           = (size_q == 16'd0) ? '0 : pat;
               tlast_d           = last_beat;
               tuser_d.mty       = ld_mty;
               tuser_d.zero_byte = size_q == 16'd0;
               beat_d            = last_beat ? 16'd0 : beat_q + 16'd1;
            end else if (accept) begin
               tvalid_d = 1'b0;
               tlast_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state_q  <= IDLE;
         run_d1_q <= 1'b0;
         size_q   <= '0;
         num_q    <= '0;
         pkt_q    <= '0;
         beat_q   <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tuser_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         run_d1_q <= control_run;
         size_q   <= size_d;
         num_q    <= num_d;
         pkt_q    <= pkt_d;
         beat_q   <= beat_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         tuser_q  <= tuser_d;
         done_q   <= done_d;
      end
   end

   assign c2h_tdata           = tdata_q;
   assign c2h_tvalid          = tvalid_q;
   assign c2h_tlast           = tlast_q;
   assign c2h_tuser_qid       = tuser_q.qid;
   assign c2h_tuser_mty       = tuser_q.mty;
   assign c2h_tuser_zero_byte = tuser_q.zero_byte;
   assign c2h_pkt_count       = pkt_q;
   assign c2h_done            = done_q;
endmodule

// File: tb/tb_st_c2h_gen.sv
// tb_st_c2h_gen: table-driven runs of st_c2h_gen (BIT_WIDTH=64) with a beat scoreboard.
module tb_st_c2h_gen;
   logic        axi_aclk = 1'b0, axi_aresetn = 1'b0, control_run = 1'b0, c2h_tready = 1'b1;
   logic [31:0] control_reg = '0, c2h_txr_size = '0, c2h_num_pkt = '0;
   logic [10:0] c2h_qid = '0;
   logic [63:0] c2h_tdata;
   logic        c2h_tvalid, c2h_tlast, c2h_tuser_zero_byte, c2h_done;
   logic [10:0] c2h_tuser_qid;
   logic [5:0]  c2h_tuser_mty;
   logic [31:0] c2h_pkt_count;
   logic [18:0] side;

   typedef struct { logic [63:0] data; logic [18:0] side; } beat_t;
   typedef struct { int size; int num; int qid; int stall_at; int drop_at; int exp_cnt; } vec_t;
   beat_t expq[$];
   vec_t  vt[8];
   int    total = 0, bad = 0;

   st_c2h_gen #(.BIT_WIDTH(64), .PATT_WIDTH(16)) dut (
      .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn), .control_reg(control_reg),
      .control_run(control_run), .c2h_txr_size(c2h_txr_size), .c2h_num_pkt(c2h_num_pkt),
      .c2h_qid(c2h_qid), .c2h_tready(c2h_tready), .c2h_tdata(c2h_tdata), .c2h_tvalid(c2h_tvalid),
      .c2h_tlast(c2h_tlast), .c2h_tuser_qid(c2h_tuser_qid), .c2h_tuser_mty(c2h_tuser_mty),
      .c2h_tuser_zero_byte(c2h_tuser_zero_byte), .c2h_pkt_count(c2h_pkt_count), .c2h_done(c2h_done)
   );

   always #5 axi_aclk = ~axi_aclk;
   assign side = {c2h_tlast, c2h_tuser_mty, c2h_tuser_zero_byte, c2h_tuser_qid};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic push_pkt(input int size, input logic [10:0] qid);
      int nb, mty;
      logic [63:0] d;
      logic [15:0] w;
      beat_t e;
      nb = (size == 0) ? 1 : (size + 7) / 8;
      for (int b = 0; b < nb; b++) begin
         mty = (b == nb - 1 && size != 0) ? nb * 8 - size : 0;
         for (int i = 0; i < 8; i++) begin
            w = 16'((b * 4 + i / 2) % 65536);
            d[8*i +: 8] = (size == 0 || i >= 8 - mty) ? 8'h00 : ((i % 2 == 1) ? w[15:8] : w[7:0]);
         end
         e.data = d;
         e.side = {b == nb - 1, 6'(mty), size == 0, qid};
         expq.push_back(e);
      end
   endtask

   logic        prev_stall = 1'b0;
   logic [63:0] prev_data;
   logic [18:0] prev_side;
   always @(negedge axi_aclk) begin
      beat_t e;
      if (!axi_aresetn) prev_stall = 1'b0;
      else begin
         if (prev_stall) begin
            check("hold_data", c2h_tdata, prev_data);
            check("hold_side", {44'd0, c2h_tvalid, side}, {44'd0, 1'b1, prev_side});
         end
         if (c2h_tvalid && c2h_tready) begin
            if (expq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_beat: got %h want none", c2h_tdata);
            end else begin
               e = expq.pop_front();
               check("beat_data", c2h_tdata, e.data);
               check("beat_side", 64'(side), 64'(e.side));
            end
         end
         prev_stall = c2h_tvalid & ~c2h_tready;
         prev_data  = c2h_tdata;
         prev_side  = side;
      end
   end

   task automatic do_run(input int size, input int num, input int qid, input int stall_at,
                         input int drop_at, input int exp_cnt);
      int cyc = 0, lat = 0, gaps = 0;
      c2h_txr_size = size;
      c2h_num_pkt  = num;
      c2h_qid      = 11'(qid);
      for (int p = 0; p < exp_cnt; p++) push_pkt(size, 11'(qid));
      control_run = 1'b1;
      while (!c2h_done && cyc < 2000) begin
         @(posedge axi_aclk); #1;
         cyc++;
         if (c2h_tvalid && lat == 0) lat = cyc;
         if (lat != 0 && !c2h_tvalid && !c2h_done) gaps++;
         if (stall_at != 0 && cyc >= stall_at && cyc <= stall_at + 3)
            check("stall_data", c2h_tdata, 64'h000B_000A_0009_0008);
         if (cyc == stall_at) c2h_tready = 1'b0;
         if (cyc == stall_at + 3) c2h_tready = 1'b1;
         if (cyc == drop_at) control_run = 1'b0;
      end
      check("done_seen", 64'(c2h_done), 64'd1);
      check("pkt_count", 64'(c2h_pkt_count), 64'(exp_cnt));
      if (num != 0) begin
         check("latency", 64'(lat), 64'd2);
         check("gaps", 64'(gaps), 64'd0);
      end
      check("sb_empty", 64'(expq.size()), 64'd0);
      @(posedge axi_aclk); #1;
      check("after_done", {30'd0, c2h_done, c2h_tvalid, c2h_pkt_count}, {32'd0, 32'(exp_cnt)});
      control_run = 1'b0;
      c2h_tready  = 1'b1;
      @(posedge axi_aclk); #1;
   endtask

   initial begin
      vt[0] = '{16, 1, 5, 0, 0, 1};
      vt[1] = '{13, 1, 7, 0, 0, 1};
      vt[2] = '{0, 2, 3, 0, 0, 2};
      vt[3] = '{24, 1, 'h7FF, 4, 0, 1};
      vt[4] = '{8, 5, 1, 0, 4, 3};
      vt[5] = '{20, 0, 4, 0, 0, 0};
      vt[6] = '{100, 2, 2, 0, 0, 2};
      vt[7] = '{1, 3, 9, 0, 0, 3};
      repeat (3) @(posedge axi_aclk);
      #1;
      check("rst_valid", {62'd0, c2h_tvalid, c2h_done}, 64'd0);
      check("rst_data", c2h_tdata, 64'd0);
      check("rst_side", 64'(side), 64'd0);
      check("rst_count", 64'(c2h_pkt_count), 64'd0);
      axi_aresetn = 1'b1;
      @(posedge axi_aclk); #1;
      for (int i = 0; i < 8; i++)
         do_run(vt[i].size, vt[i].num, vt[i].qid, vt[i].stall_at, vt[i].drop_at, vt[i].exp_cnt);
      // reset in the middle of an 8-beat packet, then a fresh run must restart at word 0
      c2h_txr_size = 64;
      c2h_num_pkt  = 1;
      c2h_qid      = 11'd6;
      push_pkt(64, 11'd6);
      control_run = 1'b1;
      repeat (4) @(posedge axi_aclk);
      #1;
      check("pre_rst_valid", 64'(c2h_tvalid), 64'd1);
      axi_aresetn = 1'b0;
      #1;
      check("mid_rst_valid", 64'(c2h_tvalid), 64'd0);
      check("mid_rst_data", c2h_tdata, 64'd0);
      check("mid_rst_count", 64'(c2h_pkt_count), 64'd0);
      expq.delete();
      control_run = 1'b0;
      @(posedge axi_aclk); #1;
      axi_aresetn = 1'b1;
      @(posedge axi_aclk); #1;
      do_run(16, 1, 6, 0, 0, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
